ps2_scan_rx: RTL and testbench

PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

---
 rtl/ps2_scan_rx.sv | 184 ++++++++++++++++++
 tb/tb_ps2_scan_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_scan_rx
//  Brief    : PS/2 keyboard receiver. Synchronizes and filters the PS/2
//             clock, deserializes 11-bit frames and folds E0/F0 prefixes
//             into ext/brk flags attached to the following scan code.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_scan_rx #(
  parameter int FILT      = 8,
  parameter int TIMEOUT   = 100000,
  parameter bit CHECK_PAR = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2d,
  input  logic       ps2c,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       brk,
  output logic       ext,
  output logic       frame_err
);

  localparam int FW = $clog2(FILT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic          ps2c_s1, ps2c_s2;
  logic          ps2d_s1, ps2d_s2;
  logic [FW-1:0] flt_cnt;
  logic          flt_lvl, flt_lvl_d;
  logic          fall_tick;

  state_t        state_q, state_n;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          pend_brk, pend_ext;

  logic          timeout_hit;
  logic          par_ok;
  logic          accept;
  logic          bad;

  // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2c_s1 <= 1'b1;
      ps2c_s2 <= 1'b1;
      ps2d_s1 <= 1'b1;
      ps2d_s2 <= 1'b1;
    end else begin
      ps2c_s1 <= ps2c;
      ps2c_s2 <= ps2c_s1;
      ps2d_s1 <= ps2d;
      ps2d_s2 <= ps2d_s1;
    end
  end

  // Clock filter: level flips only after FILT consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      flt_cnt   <= '0;
      flt_lvl   <= 1'b1;
      flt_lvl_d <= 1'b1;
    end else begin
      flt_lvl_d <= flt_lvl;
      if (ps2c_s2 == flt_lvl) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILT - 1)) begin
        flt_lvl <= ps2c_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall_tick   = flt_lvl_d & ~flt_lvl;
  assign timeout_hit = (state_q != IDLE) && !fall_tick &&
                       (tmo_cnt == TW'(TIMEOUT - 1));
  assign par_ok      = (CHECK_PAR == 1'b0) || (^{shreg, par_bit});

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Next-state logic plus accept/error strobes for the datapath.
  always_comb begin
    state_n = state_q;
    accept  = 1'b0;
    bad     = 1'b0;
    if (timeout_hit) begin
      state_n = IDLE;
      bad     = 1'b1;
    end else if (fall_tick) begin
      case (state_q)
        IDLE: begin
          if (ps2d_s2) bad = 1'b1;
          else         state_n = DATA;
        end
        DATA: begin
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: state_n = STOP;
        STOP: begin
          state_n = IDLE;
          if (ps2d_s2 && par_ok) accept = 1'b1;
          else                   bad    = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Deserializer, timeout counter, prefix tracking and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tmo_cnt    <= '0;
      pend_brk   <= 1'b0;
      pend_ext   <= 1'b0;
      code       <= '0;
      code_valid <= 1'b0;
      brk        <= 1'b0;
      ext        <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= bad;

      if (state_q == IDLE || fall_tick || timeout_hit) tmo_cnt <= '0;
      else                                            tmo_cnt <= tmo_cnt + 1'b1;

      if (fall_tick) begin
        case (state_q)
          IDLE:    bit_cnt <= '0;
          DATA: begin
            shreg   <= {ps2d_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY:  par_bit <= ps2d_s2;
          default: ;
        endcase
      end

      // A stalled frame also forgets any prefixes seen before it.
      if (timeout_hit) begin
        bit_cnt  <= '0;
        pend_brk <= 1'b0;
        pend_ext <= 1'b0;
      end

      if (accept) begin
        if (shreg == 8'hF0) begin
          pend_brk <= 1'b1;
        end else if (shreg == 8'hE0) begin
          pend_ext <= 1'b1;
        end else begin
          code       <= shreg;
          brk        <= pend_brk;
          ext        <= pend_ext;
          code_valid <= 1'b1;
          pend_brk   <= 1'b0;
          pend_ext   <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_scan_rx
//  Brief    : Self-checking bench for ps2_scan_rx. Two instances (parity
//             check off / on) share the PS/2 lines; a frame-level reference
//             model predicts pulses and decoded outputs for each.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_scan_rx;

  localparam int FILT    = 8;
  localparam int TIMEOUT = 500;
  localparam int HALF    = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2d = 1'b1;
  logic       ps2c = 1'b1;
  logic [7:0] code_o  [2];
  logic       valid_o [2];
  logic       brk_o   [2];
  logic       ext_o   [2];
  logic       err_o   [2];

  int total = 0;
  int bad   = 0;

  int nv [2] = '{0, 0};
  int ne [2] = '{0, 0};
  int base_v [2];
  int base_e [2];

  logic [7:0] m_code [2];
  logic       m_brk  [2];
  logic       m_ext  [2];
  logic       m_pb   [2];
  logic       m_pe   [2];
  int         exp_v  [2];
  int         exp_e  [2];

  always #5 clk = ~clk;

  ps2_scan_rx #(.FILT(FILT), .TIMEOUT(TIMEOUT), .CHECK_PAR(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .ps2d(ps2d), .ps2c(ps2c),
    .code(code_o[0]), .code_valid(valid_o[0]), .brk(brk_o[0]),
    .ext(ext_o[0]), .frame_err(err_o[0])
  );

  ps2_scan_rx #(.FILT(FILT), .TIMEOUT(TIMEOUT), .CHECK_PAR(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .ps2d(ps2d), .ps2c(ps2c),
    .code(code_o[1]), .code_valid(valid_o[1]), .brk(brk_o[1]),
    .ext(ext_o[1]), .frame_err(err_o[1])
  );

  // Pulse counters, sampled on the falling clock edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (valid_o[k]) nv[k] <= nv[k] + 1;
      if (err_o[k])   ne[k] <= ne[k] + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_code[k] = 8'h00; m_brk[k] = 1'b0; m_ext[k] = 1'b0;
      m_pb[k] = 1'b0;    m_pe[k] = 1'b0;
    end
  endtask

  task automatic begin_step();
    for (int k = 0; k < 2; k++) begin
      base_v[k] = nv[k]; base_e[k] = ne[k];
      exp_v[k] = 0;      exp_e[k] = 0;
    end
  endtask

  // Reference behaviour for one complete frame with a valid start bit.
  task automatic model_frame(input logic [7:0] d, input logic p, input logic s);
    int ones;
    logic ok;
    ones = $countones(d) + int'(p);
    for (int k = 0; k < 2; k++) begin
      ok = s && ((k == 0) || (ones % 2 == 1));
      if (!ok) begin
        exp_e[k] = 1;
      end else if (d == 8'hF0) begin
        m_pb[k] = 1'b1;
      end else if (d == 8'hE0) begin
        m_pe[k] = 1'b1;
      end else begin
        exp_v[k] = 1;
        m_code[k] = d; m_brk[k] = m_pb[k]; m_ext[k] = m_pe[k];
        m_pb[k] = 1'b0; m_pe[k] = 1'b0;
      end
    end
  endtask

  task automatic end_step(input string name);
    repeat (25) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s valid_cnt[%0d]", name, k), nv[k] - base_v[k], exp_v[k]);
      check($sformatf("%s err_cnt[%0d]", name, k),   ne[k] - base_e[k], exp_e[k]);
      check($sformatf("%s code[%0d]", name, k),      int'(code_o[k]), int'(m_code[k]));
      check($sformatf("%s brk[%0d]", name, k),       int'(brk_o[k]),  int'(m_brk[k]));
      check($sformatf("%s ext[%0d]", name, k),       int'(ext_o[k]),  int'(m_ext[k]));
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2d = b;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    @(negedge clk);
    ps2d = 1'b1;
  endtask

  task automatic run_frame(input string name, input logic [7:0] d,
                           input logic p, input logic s);
    begin_step();
    model_frame(d, p, s);
    send_frame(d, p, s);
    end_step(name);
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  initial begin
    logic [7:0] d;
    logic       p;
    logic       s;
    model_reset();
    repeat (5) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    begin_step();
    end_step("reset");

    // Plain make code, release prefix, following code.
    run_frame("make_1c", 8'h1C, odd_par(8'h1C), 1'b1);
    run_frame("pfx_f0",  8'hF0, odd_par(8'hF0), 1'b1);
    run_frame("brk_1c",  8'h1C, odd_par(8'h1C), 1'b1);
    run_frame("make_32", 8'h32, odd_par(8'h32), 1'b1);

    // Extended release with repeated prefixes.
    run_frame("pfx_e0",  8'hE0, odd_par(8'hE0), 1'b1);
    run_frame("pfx_f0b", 8'hF0, odd_par(8'hF0), 1'b1);
    run_frame("pfx_f0c", 8'hF0, odd_par(8'hF0), 1'b1);
    run_frame("ext_75",  8'h75, odd_par(8'h75), 1'b1);

    // Bad stop bit, then wrong parity (only the checking instance rejects).
    run_frame("stop0",   8'h1C, odd_par(8'h1C), 1'b0);
    run_frame("par_bad", 8'h1C, ~odd_par(8'h1C), 1'b1);

    // Timeout after four data bits drops the frame and a pending prefix.
    run_frame("pfx_tmo", 8'hF0, odd_par(8'hF0), 1'b1);
    begin_step();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    for (int k = 0; k < 2; k++) begin
      exp_e[k] = 1; m_pb[k] = 1'b0; m_pe[k] = 1'b0;
    end
    repeat (TIMEOUT + 200) @(negedge clk);
    end_step("timeout");
    run_frame("after_tmo", 8'h2A, odd_par(8'h2A), 1'b1);

    // Short clock glitch in idle must be ignored.
    begin_step();
    @(negedge clk);
    ps2c = 1'b0;
    repeat (5) @(negedge clk);
    ps2c = 1'b1;
    end_step("glitch");
    run_frame("after_glitch", 8'h1C, odd_par(8'h1C), 1'b1);

    // Start bit that reads high.
    begin_step();
    send_bit(1'b1);
    for (int k = 0; k < 2; k++) exp_e[k] = 1;
    end_step("bad_start");

    // Reset in the middle of a frame, with a prefix pending.
    run_frame("pfx_rst", 8'hE0, odd_par(8'hE0), 1'b1);
    begin_step();
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    end_step("mid_rst");
    run_frame("after_rst", 8'h2A, odd_par(8'h2A), 1'b1);

    // Randomized frames with prefixes, parity errors and stop errors mixed in.
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    d = 8'hF0;
        2, 3:    d = 8'hE0;
        default: d = 8'($urandom_range(0, 255));
      endcase
      p = odd_par(d);
      if ($urandom_range(0, 5) == 0) p = ~p;
      s = ($urandom_range(0, 7) != 0);
      run_frame($sformatf("rand%0d", n), d, p, s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
